// File: rtl/if_fetch_queue_pkg.sv
// Shared bus widths, constants and the queue entry layout for the fetch stage.
package if_fetch_queue_pkg;

  localparam int unsigned INST_ADDR_W       = 32;
  localparam int unsigned INST_W            = 32;
  localparam int unsigned FETCH_QUEUE_DEPTH = 4;

  localparam logic [INST_W-1:0]      ZERO_WORD    = 32'h0000_0000;
  localparam logic [INST_ADDR_W-1:0] PC_STEP      = 32'd4;
  localparam logic                   CHIP_ENABLE  = 1'b1;
  localparam logic                   CHIP_DISABLE = 1'b0;
  localparam logic                   RST_ENABLE   = 1'b0;
  localparam logic                   RST_DISABLE  = 1'b1;

  // One prefetched instruction together with the address it came from.
  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } fetch_entry_t;

  localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

  // Instructions are word aligned; stray low bits of a target are dropped.
  function automatic logic [INST_ADDR_W-1:0] align_pc(input logic [INST_ADDR_W-1:0] pc);
    return pc & ~(PC_STEP - INST_ADDR_W'(1));
  endfunction

endpackage

// File: rtl/if_fetch_queue_fetch_fifo.sv
// Synchronous FIFO holding prefetched {pc, inst} entries.
// Ports: clk, rst (sync, active-low), i_push/i_pop/i_flush controls,
//        i_data write data, o_full/o_empty status, o_head entry at read pointer.
// DEPTH must be a power of two so the pointers wrap naturally.
module if_fetch_queue_fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;

  // Pointer and occupancy tracking; flush and reset both empty the queue.
  always_ff @(posedge clk) begin
    if (!rst || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  // Storage needs no reset; occupancy decides what is visible.
  always_ff @(posedge clk) begin
    if (rst && !i_flush && i_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, reads the ROM and buffers
// returned instructions for decode behind a valid/ready handshake.
// Ports: clk, rst (sync, active-low); rom_ce_o/rom_addr_o/rom_inst_i ROM side;
//        redirect_i/redirect_pc_i flush-and-refetch from execute;
//        id_valid_o/id_ready_i/id_pc_o/id_inst_o decode side.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = FETCH_QUEUE_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_inst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o
);

  logic [INST_ADDR_W-1:0] r_fetch_pc;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_valid;
  logic                   w_run;
  fetch_entry_t           w_wr_entry;
  fetch_entry_t           w_head;

  assign w_run = (rst == RST_DISABLE);

  // ce looks only at registered occupancy, so decode ready never reaches the ROM.
  assign w_push  = w_run && !w_full && !redirect_i;
  assign w_valid = w_run && !w_empty && !redirect_i;
  assign w_pop   = w_valid && id_ready_i;

  assign w_wr_entry = '{pc: r_fetch_pc, inst: rom_inst_i};

  // Fetch PC: reset, redirect, then sequential advance on each ROM read.
  always_ff @(posedge clk) begin
    if (!w_run) begin
      r_fetch_pc <= RESET_PC;
    end else if (redirect_i) begin
      r_fetch_pc <= align_pc(redirect_pc_i);
    end else if (w_push) begin
      r_fetch_pc <= r_fetch_pc + PC_STEP;
    end
  end

  if_fetch_queue_fetch_fifo #(
    .WIDTH(FETCH_ENTRY_W),
    .DEPTH(QUEUE_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_flush(redirect_i),
    .i_data (w_wr_entry),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_head (w_head)
  );

  // Outputs are forced quiet while reset is asserted.
  assign rom_ce_o   = w_push ? CHIP_ENABLE : CHIP_DISABLE;
  assign rom_addr_o = w_run ? r_fetch_pc : '0;
  assign id_valid_o = w_valid;
  assign id_pc_o    = (w_run && !w_empty) ? w_head.pc   : '0;
  assign id_inst_o  = (w_run && !w_empty) ? w_head.inst : ZERO_WORD;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized bench for if_fetch_queue against a queue-based reference model.
module tb_if_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RST_PC   = 32'h0000_0000;
  localparam logic [31:0] ROM_SALT = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_inst_i;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        id_valid_o;
  logic        id_ready_i = 1'b0;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: the fetch address and the instructions waiting for decode.
  logic [31:0] m_pc = RST_PC;
  logic [31:0] m_q_pc[$];

  always #5 clk = ~clk;

  // Combinational ROM model.
  assign rom_inst_i = rom_addr_o ^ ROM_SALT;

  if_fetch_queue #(
    .RESET_PC   (RST_PC),
    .QUEUE_DEPTH(DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rom_ce_o     (rom_ce_o),
    .rom_addr_o   (rom_addr_o),
    .rom_inst_i   (rom_inst_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .id_valid_o   (id_valid_o),
    .id_ready_i   (id_ready_i),
    .id_pc_o      (id_pc_o),
    .id_inst_o    (id_inst_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic step(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy);
    logic        e_ce;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    @(negedge clk);
    rst           = r;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    id_ready_i    = rdy;
    #1;
    e_ce    = r && (m_q_pc.size() < DEPTH) && !rd;
    e_valid = r && (m_q_pc.size() != 0) && !rd;
    e_pc    = (r && m_q_pc.size() != 0) ? m_q_pc[0] : 32'h0;
    e_inst  = (r && m_q_pc.size() != 0) ? (m_q_pc[0] ^ ROM_SALT) : 32'h0;
    check("rom_ce",   32'(rom_ce_o),   32'(e_ce));
    check("rom_addr", rom_addr_o,      r ? m_pc : 32'h0);
    check("id_valid", 32'(id_valid_o), 32'(e_valid));
    check("id_pc",    id_pc_o,         e_pc);
    check("id_inst",  id_inst_o,       e_inst);
    @(posedge clk);
    if (!r) begin
      m_q_pc.delete();
      m_pc = RST_PC;
    end else if (rd) begin
      m_q_pc.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (e_valid && rdy) void'(m_q_pc.pop_front());
      if (e_ce) begin
        m_q_pc.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  initial begin
    // Reset held, then streaming with decode always ready.
    repeat (3)  step(1'b0, 1'b0, 32'h0, 1'b1);
    repeat (8)  step(1'b1, 1'b0, 32'h0, 1'b1);
    // Back-pressure until full, then drain.
    repeat (10) step(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (6)  step(1'b1, 1'b0, 32'h0, 1'b1);
    // Refill, then redirect from a full queue.
    repeat (4)  step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 32'h0000_0100, 1'b0);
    repeat (4)  step(1'b1, 1'b0, 32'h0, 1'b1);
    // Misaligned target with decode ready on a non-empty queue.
    step(1'b1, 1'b1, 32'h0000_0206, 1'b1);
    repeat (5)  step(1'b1, 1'b0, 32'h0, 1'b1);
    // Partially fill then reset mid-stream.
    repeat (2)  step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    repeat (5)  step(1'b1, 1'b0, 32'h0, 1'b1);
    // Fetch address wrapping past 2^32.
    step(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
    repeat (6)  step(1'b1, 1'b0, 32'h0, 1'b1);
    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic        r;
      logic        rd;
      logic [31:0] rpc;
      logic        rdy;
      r   = ($urandom_range(0, 49) != 0);
      rd  = ($urandom_range(0, 11) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      rdy = ($urandom_range(0, 3) != 0);
      step(r, rd, rpc, rdy);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Instruction-fetch stage that sits directly upstream of the instruction ROM.
- Owns the fetch PC and drives the ROM chip-enable and address.
- Captures each returned instruction, with its PC, into a small prefetch queue.
- Presents the queue head to the decode stage over a valid/ready handshake; a redirect from execute flushes the queue and restarts fetch.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- QUEUE_DEPTH, 4, number of {pc, inst} entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-low reset (sampled on rising clk; 0 = reset)
- rom_ce_o  output  1  ROM chip enable (`ChipEnable/`ChipDisable)
- rom_addr_o  output  `InstAddrBus  byte address to ROM
- rom_inst_i  input  `InstBus  ROM data; combinational, valid in the same cycle as rom_addr_o
- redirect_i  input  1  branch/jump taken; flush and refetch
- redirect_pc_i  input  `InstAddrBus  new fetch target
- id_valid_o  output  1  queue head valid toward decode
- id_ready_i  input  1  decode accepts the head this cycle
- id_pc_o  output  `InstAddrBus  PC of the head entry
- id_inst_o  output  `InstBus  instruction of the head entry

Behaviour:
- State: fetch_pc (32b), queue storage, rd_ptr/wr_ptr (log2 QUEUE_DEPTH bits), count (log2 QUEUE_DEPTH + 1 bits).
- Reset (rst==0 at a clk edge): fetch_pc=RESET_PC; pointers=0; count=0.
- While rst==0, outputs are forced combinationally: rom_ce_o=0, rom_addr_o=0, id_valid_o=0, id_pc_o=0, id_inst_o=`ZeroWord.
- Address and enable:
  - rom_addr_o = fetch_pc.
  - rom_ce_o = rst && !full && !redirect_i, where full = (count==QUEUE_DEPTH).
- Push (edge where rom_ce_o==1): write {fetch_pc, rom_inst_i} at wr_ptr; wr_ptr++; fetch_pc += 4.
- Decode output:
  - id_valid_o = rst && (count!=0) && !redirect_i.
  - id_pc_o/id_inst_o = entry at rd_ptr when count!=0, otherwise 0/`ZeroWord.
- Pop (edge where id_valid_o && id_ready_i): rd_ptr++.
- Count update: count += push - pop.
  - Simultaneous push and pop leaves count unchanged.
  - Full blocks push even if a pop occurs in the same cycle; ce depends only on registered count, so there is no ready→ce combinational path.
- Empty: id_valid_o=0; id_ready_i is ignored.
- Redirect (edge with redirect_i==1 and rst==1):
  - pointers=0, count=0.
  - fetch_pc = {redirect_pc_i[31:2], 2'b00}; low bits are silently forced to zero.
  - No push and no pop occur that cycle.
  - Redirect overrides every other event.
- Latency:
  - Reset released at edge t0 → ROM read of RESET_PC during cycle after t0 → id_valid_o=1 one cycle later.
  - Redirect asserted in cycle t → ROM read of the target in t+1 → target visible at decode in t+2.
  - Steady-state throughput is one instruction per cycle when decode is always ready.
- Wrap-around: pointers wrap modulo QUEUE_DEPTH; fetch_pc wraps modulo 2^32 without error.
- Reset mid-operation: all in-flight entries are discarded; the next fetch after release is RESET_PC.

Decomposition:
- Shared defines file provides `InstAddrBus, `InstBus, `ZeroWord, `ChipEnable, `ChipDisable, `RstEnable (1'b0), `RstDisable (1'b1).
- Shared defines file also gains `FetchQueueDepth (4) and `PcStep (32'd4).
- One sub-module is natural: fetch_fifo, a synchronous FIFO parameterised on width/depth.
  - Inputs: push, pop, flush.
  - Outputs: full, empty, head.
  - if_fetch_queue instantiates it with width 64 ({pc, inst}) and keeps fetch_pc/redirect logic at top level.

Test Plan:
ROM model returns inst = addr ^ 32'hA5A5_0000.
- Reset held 3 cycles, then released with id_ready_i=1 → no ce during reset; head sequence pc=0,4,8,C with inst=A5A50000, A5A50004, …; one per cycle; first valid 2 cycles after release.
- id_ready_i=0 for 10 cycles → count reaches 4; rom_ce_o=0 while full; head held at pc=0. Then ready=1 → pcs 0,4,8,C,10 in consecutive cycles, with no gap and no duplicate.
- Queue full, redirect_i=1 with redirect_pc_i=32'h0000_0100 → id_valid_o=0 that cycle; next cycle rom_addr_o=100, ce=1; following cycle head pc=100, inst=A5A50100; the old entries never appear.
- redirect_pc_i=32'h0000_0206 → fetch restarts at 204.
- redirect_i and id_ready_i both high with a non-empty queue → no pop is counted; the head after the flush is the target.
- rst driven low mid-stream at pc=40 with queue half full → next cycle all outputs are zero; after release, fetch restarts at RESET_PC=0 and no stale entries are delivered.
